pipe_stage_buf: RTL and testbench

- Parametrised, elastic successor to the fixed per-stage pipeline latches (IF/ID … MEM/WB).
- One instance sits between two stages and carries one payload word, one control word and a halted flag per instruction.
- Adds a valid/ready handshake, stall with a 1-entry skid, flush (bubble insert) and halt-drain, so hazard logic no longer gates individual dffs.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_entry.sv | 45 ++++
 rtl/pipe_stage_buf.sv | 117 +++++++++++
 tb/tb_pipe_stage_buf.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, default widths and MEM/WB control word layout for pipe_stage_buf
package pipe_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] reg_src;
    logic       is_word;
    logic [1:0] byte_number;
    logic [1:0] spare;
  } memwb_ctrl_t;
  localparam int DEF_DATA_W = 104;
  localparam int DEF_CTRL_W = $bits(memwb_ctrl_t);
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one {valid, halted, ctrl, data} holding register with load and clear
module pipe_entry #(
  parameter int DATA_W = 104,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic              i_halted,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_halted,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic              r_halted;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  // clear beats load so a squashed word never lands; cleared entries read as all-zero bubbles
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_ctrl   <= '0;
      r_data   <= '0;
    end else if (i_clear) begin
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_ctrl   <= '0;
      r_data   <= '0;
    end else if (i_load) begin
      r_valid  <= i_valid;
      r_halted <= i_halted;
      r_ctrl   <= i_ctrl;
      r_data   <= i_data;
    end
  assign o_valid  = r_valid;
  assign o_halted = r_halted;
  assign o_ctrl   = r_ctrl;
  assign o_data   = r_data;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic inter-stage buffer with skid, flush and halt drain; PIPE_STAGE_TRACE_EN adds transfer trace and protocol checks
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int CTRL_W        = DEF_CTRL_W,
  parameter int SKID_EN_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_halted,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_halted,
  output logic [1:0]        occupancy
);
  state_t            r_state;
  state_t            w_next;
  logic              r_halt_seen;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_from_skid;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_main_valid;
  logic              w_main_halted;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_valid;
  logic              w_skid_halted;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_src_halted;
  logic [CTRL_W-1:0] w_src_ctrl;
  logic [DATA_W-1:0] w_src_data;
  // state register
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r_state <= EMPTY;
    else r_state <= w_next;
  // an accepted halt closes the input until flush or reset; a flushed halt never counts
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r_halt_seen <= 1'b0;
    else if (flush) r_halt_seen <= 1'b0;
    else if (w_in_xfer && in_halted) r_halt_seen <= 1'b1;
  // handshake, next state and steering of the main/skid entries
  always_comb begin
    w_in_ready   = (SKID_EN_DEPTH != 0) ? (r_state != TWO) && !r_halt_seen
                                        : (!w_main_valid || out_ready) && !r_halt_seen;
    w_in_xfer    = in_valid && w_in_ready;
    w_from_skid  = (r_state == TWO) && out_ready;
    w_main_load  = w_from_skid || (w_in_xfer && ((r_state == EMPTY) || out_ready));
    w_main_clear = flush || ((r_state == ONE) && !w_in_xfer && out_ready);
    w_skid_load  = (SKID_EN_DEPTH != 0) && (r_state == ONE) && w_in_xfer && !out_ready;
    w_skid_clear = flush || w_from_skid;
    w_src_halted = (r_state == TWO) ? w_skid_halted : in_halted;
    w_src_ctrl   = (r_state == TWO) ? w_skid_ctrl : in_ctrl;
    w_src_data   = (r_state == TWO) ? w_skid_data : in_data;
    w_next       = flush ? EMPTY :
                   (r_state == EMPTY) ? (w_in_xfer ? ONE : EMPTY) :
                   (r_state == ONE) ? (w_in_xfer ? ((out_ready || SKID_EN_DEPTH == 0) ? ONE : TWO)
                                                 : (out_ready ? EMPTY : ONE)) :
                   (out_ready ? ONE : TWO);
  end
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_valid (1'b1),
    .i_halted(w_src_halted),
    .i_ctrl  (w_src_ctrl),
    .i_data  (w_src_data),
    .o_valid (w_main_valid),
    .o_halted(w_main_halted),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_valid (1'b1),
    .i_halted(in_halted),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_halted(w_skid_halted),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );
  assign in_ready   = w_in_ready;
  assign out_valid  = w_main_valid;
  assign out_data   = w_main_valid ? w_main_data : '0;
  assign out_ctrl   = w_main_valid ? w_main_ctrl : '0;
  assign out_halted = w_main_valid && w_main_halted;
  assign occupancy  = r_state;
`ifdef PIPE_STAGE_TRACE_EN
  // trace each downstream transfer and flag handshake or bubble violations
  always @(posedge clk)
    if (rst_b && out_valid && out_ready)
      $display("%0t pipe_stage_buf ctrl=%0h halted=%0b occ=%0d", $time, out_ctrl, out_halted, occupancy);
  a_in_hold: assert property (@(posedge clk) disable iff (!rst_b)
    (in_valid && !in_ready && !flush) |=> in_valid);
  a_bubble: assert property (@(posedge clk) disable iff (!rst_b)
    !out_valid |-> (out_ctrl == '0));
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: random and directed stimulus against a queue model, skid depth 1 and 0 side by side
module tb_pipe_stage_buf;
  typedef struct {
    logic [103:0] d;
    logic [7:0]   c;
    logic         h;
  } ent_t;
  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         iv = 1'b0, ordy = 1'b0, fl = 1'b0, hd = 1'b0;
  logic [103:0] din = '0;
  logic [7:0]   cin = '0;
  logic         rdy1, ov1, oh1, rdy0, ov0, oh0;
  logic [103:0] od1, od0;
  logic [7:0]   oc1, oc0;
  logic [1:0]   occ1, occ0;
  int           total = 0;
  int           bad = 0;
  ent_t         q1[$];
  ent_t         q0[$];
  bit           h1 = 0, h0 = 0;
  always #5 clk = ~clk;
  pipe_stage_buf #(.SKID_EN_DEPTH(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .in_valid(iv), .in_ready(rdy1), .in_data(din), .in_ctrl(cin),
    .in_halted(hd), .flush(fl), .out_valid(ov1), .out_ready(ordy), .out_data(od1),
    .out_ctrl(oc1), .out_halted(oh1), .occupancy(occ1)
  );
  pipe_stage_buf #(.SKID_EN_DEPTH(0)) dut0 (
    .clk(clk), .rst_b(rst_b), .in_valid(iv), .in_ready(rdy0), .in_data(din), .in_ctrl(cin),
    .in_halted(hd), .flush(fl), .out_valid(ov0), .out_ready(ordy), .out_data(od0),
    .out_ctrl(oc0), .out_halted(oh0), .occupancy(occ0)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit v, input bit r, input bit f, input bit h, input logic [103:0] d);
    ent_t e, a1, a0;
    bit   x1, x0;
    @(negedge clk);
    e.d = d;
    e.c = 8'($urandom);
    e.h = h;
    iv = v; ordy = r; fl = f; hd = h; din = e.d; cin = e.c;
    #1;
    x1 = (q1.size() < 2) && !h1;
    x0 = (q0.size() == 0 || r) && !h0;
    a1 = '{d: '0, c: '0, h: 1'b0};
    a0 = '{d: '0, c: '0, h: 1'b0};
    if (q1.size() != 0) a1 = q1[0];
    if (q0.size() != 0) a0 = q0[0];
    chk("rdy1", 128'(rdy1), 128'(x1));
    chk("vld1", 128'(ov1), 128'(q1.size() != 0));
    chk("occ1", 128'(occ1), 128'(q1.size()));
    chk("dat1", 128'(od1), 128'(a1.d));
    chk("ctl1", 128'(oc1), 128'(a1.c));
    chk("hlt1", 128'(oh1), 128'(a1.h));
    chk("rdy0", 128'(rdy0), 128'(x0));
    chk("vld0", 128'(ov0), 128'(q0.size() != 0));
    chk("occ0", 128'(occ0), 128'(q0.size()));
    chk("dat0", 128'(od0), 128'(a0.d));
    chk("ctl0", 128'(oc0), 128'(a0.c));
    chk("hlt0", 128'(oh0), 128'(a0.h));
    if (f) begin
      q1.delete(); q0.delete(); h1 = 0; h0 = 0;
    end else begin
      if (q1.size() != 0 && r) void'(q1.pop_front());
      if (q0.size() != 0 && r) void'(q0.pop_front());
      if (v && x1) begin q1.push_back(e); h1 = h1 | h; end
      if (v && x0) begin q0.push_back(e); h0 = h0 | h; end
    end
  endtask
  function automatic logic [103:0] rnd_d();
    return 104'({$urandom, $urandom, $urandom, $urandom});
  endfunction
  initial begin
    @(negedge clk);
    #1;
    chk("rst_occ1", 128'(occ1), 128'(0));
    chk("rst_vld1", 128'(ov1), 128'(0));
    chk("rst_ctl1", 128'(oc1), 128'(0));
    chk("rst_dat1", 128'(od1), 128'(0));
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rst_rdy1", 128'(rdy1), 128'(1));
    chk("rst_rdy0", 128'(rdy0), 128'(1));
    for (int i = 1; i <= 5; i++) step(1, 1, 0, 0, 104'(i));
    repeat (2) step(0, 1, 0, 0, '0);
    step(1, 0, 0, 0, 104'hA);
    step(1, 0, 0, 0, 104'hB);
    step(0, 0, 0, 0, '0);
    chk("skid_occ", 128'(occ1), 128'(2));
    chk("skid_rdy", 128'(rdy1), 128'(0));
    chk("skid_dat", 128'(od1), 128'(104'hA));
    repeat (3) step(0, 1, 0, 0, '0);
    step(1, 0, 0, 0, 104'hA);
    step(1, 0, 0, 0, 104'hB);
    step(1, 0, 1, 0, 104'hC);
    step(0, 0, 0, 0, '0);
    chk("flush_vld", 128'(ov1), 128'(0));
    chk("flush_occ", 128'(occ1), 128'(0));
    step(1, 1, 0, 1, 104'h5A);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, rnd_d());
    chk("halt_rdy", 128'(rdy1), 128'(0));
    step(0, 1, 1, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("halt_rel", 128'(rdy1), 128'(1));
    step(1, 0, 0, 0, 104'hA);
    step(1, 0, 0, 0, 104'hB);
    @(negedge clk);
    iv = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_occ1", 128'(occ1), 128'(0));
    chk("arst_vld1", 128'(ov1), 128'(0));
    chk("arst_dat1", 128'(od1), 128'(0));
    chk("arst_occ0", 128'(occ0), 128'(0));
    q1.delete(); q0.delete(); h1 = 0; h0 = 0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) step(1, i % 3 != 1, 0, 0, rnd_d());
    for (int i = 0; i < 400; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 6, $urandom_range(11, 0) == 0,
           $urandom_range(15, 0) == 0, rnd_d());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
